// File: rtl/lockout_pkg.sv
// Shared types and constants for the keypad lockout alarm.
package lockout_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOCK_SHORT,
        LOCK_LONG,
        ALARM
    } state_t;

    localparam int ALARM_THRESH  = 4;
    localparam int LONG_THRESH   = 3;
    localparam int TICKS_PER_SEC = 8;

endpackage

// File: rtl/lockout_tick_gen.sv
// Divides clk into an eighth-second tick and a one-second pulse; clr restarts both
// so a lockout can begin on an exact second boundary.
module lockout_tick_gen
    import lockout_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick8,
    output logic sec
);

    localparam int DIV = CLK_HZ / TICKS_PER_SEC;
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;

    logic [DW-1:0] div_reg;
    logic [2:0]    tcnt_reg;

    assign tick8 = (div_reg == DW'(DIV - 1));
    assign sec   = tick8 && (tcnt_reg == 3'(TICKS_PER_SEC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_reg  <= '0;
            tcnt_reg <= '0;
        end else if (clr) begin
            div_reg  <= '0;
            tcnt_reg <= '0;
        end else begin
            div_reg <= tick8 ? '0 : div_reg + 1'b1;
            if (tick8)
                tcnt_reg <= tcnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/lockout_alarm.sv
// Keypad wrong-entry lockout with escalating lockout times and an alarm state.
// Define LOCKOUT_IDLE_EN to build the idle-timeout indicator channel.
module lockout_alarm
    import lockout_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int ERR_W  = 4,
    parameter int T1_S   = 5,
    parameter int T2_S   = 30,
    parameter int IDLE_S = 30
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             err_pulse,
    input  logic             ok_pulse,
    input  logic             admin_clr,
    input  logic             activity,
    output logic             locked,
    output logic             lock_led,
    output logic             idle_led,
    output logic [ERR_W-1:0] err_cnt,
    output logic [7:0]       lock_remain
);

    state_t           state_reg;
    logic [ERR_W-1:0] err_cnt_reg;
    logic [ERR_W-1:0] err_inc;
    logic [7:0]       lock_remain_reg;
    logic             locked_reg;
    logic             lock_led_reg;
    logic             lock_entry;
    logic             tick8;
    logic             sec;

    assign err_inc    = (err_cnt_reg == '1) ? err_cnt_reg : err_cnt_reg + 1'b1;
    assign lock_entry = (state_reg == IDLE) && err_pulse && !admin_clr;

    lockout_tick_gen #(.CLK_HZ(CLK_HZ)) tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (lock_entry),
        .tick8 (tick8),
        .sec   (sec)
    );

    // lock_led doubles as the blink phase: set on entry, toggled every tick8.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            err_cnt_reg     <= '0;
            lock_remain_reg <= '0;
            locked_reg      <= 1'b0;
            lock_led_reg    <= 1'b0;
        end else if (admin_clr) begin
            state_reg       <= IDLE;
            err_cnt_reg     <= '0;
            lock_remain_reg <= '0;
            locked_reg      <= 1'b0;
            lock_led_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    locked_reg   <= 1'b0;
                    lock_led_reg <= 1'b0;
                    if (err_pulse) begin
                        err_cnt_reg  <= err_inc;
                        locked_reg   <= 1'b1;
                        lock_led_reg <= 1'b1;
                        if (32'(err_inc) >= ALARM_THRESH) begin
                            state_reg       <= ALARM;
                            lock_remain_reg <= '0;
                        end else if (32'(err_inc) == LONG_THRESH) begin
                            state_reg       <= LOCK_LONG;
                            lock_remain_reg <= 8'(T2_S);
                        end else begin
                            state_reg       <= LOCK_SHORT;
                            lock_remain_reg <= 8'(T1_S);
                        end
                    end else if (ok_pulse) begin
                        err_cnt_reg <= '0;
                    end
                end
                LOCK_SHORT, LOCK_LONG: begin
                    if (tick8)
                        lock_led_reg <= ~lock_led_reg;
                    if (sec) begin
                        if (lock_remain_reg <= 8'd1) begin
                            state_reg       <= IDLE;
                            lock_remain_reg <= '0;
                            locked_reg      <= 1'b0;
                            lock_led_reg    <= 1'b0;
                        end else begin
                            lock_remain_reg <= lock_remain_reg - 8'd1;
                        end
                    end
                end
                ALARM: begin
                    locked_reg      <= 1'b1;
                    lock_led_reg    <= 1'b1;
                    lock_remain_reg <= '0;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign locked      = locked_reg;
    assign lock_led    = lock_led_reg;
    assign err_cnt     = err_cnt_reg;
    assign lock_remain = lock_remain_reg;

`ifdef LOCKOUT_IDLE_EN
    localparam int IW = $clog2(IDLE_S + 1);

    logic [IW-1:0] idle_sec_reg;
    logic          idle_blink_reg;
    logic          idle_led_reg;

    // Alternates between IDLE_S quiet seconds and IDLE_S blinking seconds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_sec_reg   <= '0;
            idle_blink_reg <= 1'b0;
            idle_led_reg   <= 1'b0;
        end else if (activity) begin
            idle_sec_reg   <= '0;
            idle_blink_reg <= 1'b0;
            idle_led_reg   <= 1'b0;
        end else if (sec && (idle_sec_reg == IW'(IDLE_S - 1))) begin
            idle_sec_reg   <= '0;
            idle_blink_reg <= ~idle_blink_reg;
            idle_led_reg   <= ~idle_blink_reg;
        end else begin
            if (sec)
                idle_sec_reg <= idle_sec_reg + 1'b1;
            if (idle_blink_reg && tick8)
                idle_led_reg <= ~idle_led_reg;
        end
    end

    assign idle_led = idle_led_reg;
`else
    logic unused_activity;
    assign unused_activity = activity;
    assign idle_led        = 1'b0;
`endif

endmodule

// File: tb/tb_lockout_alarm.sv
// Randomized self-checking bench for lockout_alarm against a time-based reference model.
module tb_lockout_alarm;

    localparam int CLK_HZ = 16;
    localparam int ERR_W  = 4;
    localparam int T1_S   = 5;
    localparam int T2_S   = 30;
    localparam int IDLE_S = 3;
    localparam int TICK   = CLK_HZ / 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             err_pulse = 1'b0;
    logic             ok_pulse = 1'b0;
    logic             admin_clr = 1'b0;
    logic             activity = 1'b0;
    logic             locked;
    logic             lock_led;
    logic             idle_led;
    logic [ERR_W-1:0] err_cnt;
    logic [7:0]       lock_remain;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lockout_alarm #(
        .CLK_HZ(CLK_HZ), .ERR_W(ERR_W), .T1_S(T1_S), .T2_S(T2_S), .IDLE_S(IDLE_S)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .err_pulse   (err_pulse),
        .ok_pulse    (ok_pulse),
        .admin_clr   (admin_clr),
        .activity    (activity),
        .locked      (locked),
        .lock_led    (lock_led),
        .idle_led    (idle_led),
        .err_cnt     (err_cnt),
        .lock_remain (lock_remain)
    );

    // Reference model: a lockout is a time window starting at edge m_start and
    // lasting m_t seconds; every output is derived from elapsed cycles.
    int ncyc;
    int m_err;
    bit m_alarm;
    bit m_lock;
    int m_start;
    int m_t;

    function automatic bit m_locked();
        return m_alarm || (m_lock && (ncyc - m_start) < m_t * CLK_HZ);
    endfunction

    function automatic bit m_led();
        if (m_alarm) return 1'b1;
        if (!m_locked()) return 1'b0;
        return (((ncyc - m_start) / TICK) % 2) == 0;
    endfunction

    function automatic int m_remain();
        if (m_alarm || !m_locked()) return 0;
        return m_t - (ncyc - m_start) / CLK_HZ;
    endfunction

    function automatic bit m_idle_led();
        int p;
        p = ncyc % (2 * IDLE_S * CLK_HZ);
        if (p < IDLE_S * CLK_HZ) return 1'b0;
        return (((p - IDLE_S * CLK_HZ) / TICK) % 2) == 0;
    endfunction

    task automatic step(input bit e, input bit o, input bit a, input bit act);
        bit was_locked;
        was_locked = m_locked();
        err_pulse = e; ok_pulse = o; admin_clr = a; activity = act;
        @(posedge clk); #1;
        err_pulse = 1'b0; ok_pulse = 1'b0; admin_clr = 1'b0; activity = 1'b0;
        ncyc++;
        if (a) begin
            m_err = 0; m_alarm = 1'b0; m_lock = 1'b0;
        end else if (!was_locked) begin
            if (e) begin
                if (m_err < (1 << ERR_W) - 1) m_err++;
                if (m_err >= 4) begin
                    m_alarm = 1'b1;
                end else begin
                    m_lock = 1'b1; m_start = ncyc; m_t = (m_err == 3) ? T2_S : T1_S;
                end
            end else if (o) begin
                m_err = 0;
            end
        end
    endtask

    task automatic model_clear();
        ncyc = 0; m_err = 0; m_alarm = 1'b0; m_lock = 1'b0; m_start = 0; m_t = 0;
    endtask

    task automatic do_reset();
        @(negedge clk); #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_clear();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %b want 0", locked); end
        checks++; if (lock_led !== 1'b0) begin errors++; $display("FAIL reset_lock_led got %b want 0", lock_led); end
        checks++; if (idle_led !== 1'b0) begin errors++; $display("FAIL reset_idle_led got %b want 0", idle_led); end
        checks++; if (err_cnt !== '0) begin errors++; $display("FAIL reset_err_cnt got %0d want 0", err_cnt); end
        checks++; if (lock_remain !== 8'd0) begin errors++; $display("FAIL reset_remain got %0d want 0", lock_remain); end
        rst_n = 1'b1;
        model_clear();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (locked !== 1'b1 || err_cnt !== ERR_W'(1)) begin
            errors++; $display("FAIL first_edge locked=%b want 1 err_cnt=%0d want 1", locked, err_cnt);
        end
    endtask

    task automatic test_single_err();
        int lc;
        do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        lc = 0;
        for (int i = 0; i < 100; i++) begin
            checks++;
            if (locked !== m_locked() || lock_led !== m_led() || err_cnt !== ERR_W'(m_err) || lock_remain !== 8'(m_remain())) begin
                errors++;
                $display("FAIL single n=%0d locked=%b want %b led=%b want %b err_cnt=%0d want %0d remain=%0d want %0d",
                         ncyc, locked, m_locked(), lock_led, m_led(), err_cnt, m_err, lock_remain, m_remain());
            end
            if (locked) lc++;
            step(1'b0, 1'b0, 1'b0, 1'b0);
        end
        checks++; if (lc !== 80) begin errors++; $display("FAIL single_duration got %0d want 80", lc); end
        checks++; if (err_cnt !== ERR_W'(1)) begin errors++; $display("FAIL single_err_cnt got %0d want 1", err_cnt); end
    endtask

    task automatic test_three_alarm();
        int lc;
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            lc = 0;
            for (int i = 0; i < 600; i++) begin
                checks++;
                if (locked !== m_locked() || lock_led !== m_led() || err_cnt !== ERR_W'(m_err) || lock_remain !== 8'(m_remain())) begin
                    errors++;
                    $display("FAIL lockout%0d n=%0d locked=%b want %b led=%b want %b err_cnt=%0d want %0d remain=%0d want %0d",
                             k + 2, ncyc, locked, m_locked(), lock_led, m_led(), err_cnt, m_err, lock_remain, m_remain());
                end
                if (locked) lc++;
                if (!m_locked()) break;
                step(m_locked() && $urandom_range(0, 9) == 0, m_locked() && $urandom_range(0, 9) == 0, 1'b0, 1'b0);
            end
            checks++;
            if (lc !== ((k == 0) ? 80 : 480)) begin
                errors++; $display("FAIL lockout%0d_duration got %0d want %0d", k + 2, lc, (k == 0) ? 80 : 480);
            end
        end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 1000; i++) begin
            checks++;
            if (locked !== m_locked() || lock_led !== m_led() || err_cnt !== ERR_W'(m_err) || lock_remain !== 8'(m_remain())) begin
                errors++;
                $display("FAIL alarm n=%0d locked=%b want %b led=%b want %b err_cnt=%0d want %0d remain=%0d want %0d",
                         ncyc, locked, m_locked(), lock_led, m_led(), err_cnt, m_err, lock_remain, m_remain());
            end
            step($urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0, 1'b0, 1'b0);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (err_cnt !== '0 || locked !== 1'b0 || lock_led !== 1'b0) begin
            errors++; $display("FAIL admin_clr err_cnt=%0d want 0 locked=%b want 0 led=%b want 0", err_cnt, locked, lock_led);
        end
    endtask

    task automatic test_coincide();
        do_reset();
        step(1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (err_cnt !== ERR_W'(1) || locked !== 1'b1 || lock_remain !== 8'd5) begin
            errors++; $display("FAIL coincide err_cnt=%0d want 1 locked=%b want 1 remain=%0d want 5", err_cnt, locked, lock_remain);
        end
    endtask

    task automatic test_err_during_lock();
        repeat (20) step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (err_cnt !== ERR_W'(1) || lock_remain !== 8'(m_remain()) || m_remain() != 4) begin
            errors++; $display("FAIL err_in_lock err_cnt=%0d want 1 remain=%0d want 4", err_cnt, lock_remain);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (err_cnt !== ERR_W'(1)) begin errors++; $display("FAIL ok_in_lock err_cnt=%0d want 1", err_cnt); end
        for (int i = 0; i < 200 && m_locked(); i++) step(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (locked !== 1'b0 || lock_remain !== 8'd0) begin
            errors++; $display("FAIL lock_expiry locked=%b want 0 remain=%0d want 0", locked, lock_remain);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (err_cnt !== '0) begin errors++; $display("FAIL ok_clears err_cnt=%0d want 0", err_cnt); end
    endtask

    task automatic test_reset_mid_long();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            if (k < 2)
                for (int i = 0; i < 200 && m_locked(); i++) step(1'b0, 1'b0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 600 && m_remain() != 17; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (locked !== 1'b1 || lock_remain !== 8'd17 || err_cnt !== ERR_W'(3)) begin
            errors++; $display("FAIL pre_reset locked=%b want 1 remain=%0d want 17 err_cnt=%0d want 3", locked, lock_remain, err_cnt);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (locked !== 1'b0 || lock_led !== 1'b0 || idle_led !== 1'b0 || err_cnt !== '0 || lock_remain !== 8'd0) begin
            errors++;
            $display("FAIL async_reset locked=%b led=%b idle=%b err_cnt=%0d remain=%0d want all 0",
                     locked, lock_led, idle_led, err_cnt, lock_remain);
        end
        @(negedge clk); rst_n = 1'b1;
        model_clear();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (err_cnt !== ERR_W'(1) || locked !== 1'b1 || lock_remain !== 8'd5) begin
            errors++; $display("FAIL post_reset err_cnt=%0d want 1 locked=%b want 1 remain=%0d want 5", err_cnt, locked, lock_remain);
        end
    endtask

    task automatic test_idle();
        do_reset();
`ifdef LOCKOUT_IDLE_EN
        for (int i = 0; i < 156; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            checks++;
            if (idle_led !== m_idle_led()) begin
                errors++; $display("FAIL idle_timing n=%0d idle_led=%b want %b", ncyc, idle_led, m_idle_led());
            end
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (idle_led !== 1'b0) begin errors++; $display("FAIL idle_activity idle_led=%b want 0", idle_led); end
        for (int i = 0; i < 32; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            checks++;
            if (idle_led !== 1'b0) begin errors++; $display("FAIL idle_restart n=%0d idle_led=%b want 0", i, idle_led); end
        end
`else
        for (int i = 0; i < 200; i++) begin
            step(1'b0, 1'b0, 1'b0, $urandom_range(0, 7) == 0);
            checks++;
            if (idle_led !== 1'b0) begin errors++; $display("FAIL idle_disabled n=%0d idle_led=%b want 0", ncyc, idle_led); end
        end
`endif
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 249) == 0, 1'b0);
            checks++;
            if (locked !== m_locked() || lock_led !== m_led() || err_cnt !== ERR_W'(m_err) || lock_remain !== 8'(m_remain())) begin
                errors++;
                $display("FAIL random n=%0d locked=%b want %b led=%b want %b err_cnt=%0d want %0d remain=%0d want %0d",
                         ncyc, locked, m_locked(), lock_led, m_led(), err_cnt, m_err, lock_remain, m_remain());
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_single_err();
        test_three_alarm();
        test_coincide();
        test_err_during_lock();
        test_reset_mid_long();
        test_idle();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
